// File: rtl/serial_pkg.sv
// Shared constants, FSM state type and frame-size helper for serial_tx_fifo.
// The BREAK state exists only when SERIAL_TX_BREAK_EN is defined.
package serial_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
`ifdef SERIAL_TX_BREAK_EN
        ,
        ST_BREAK
`endif
    } state_e;

    // Bit periods in one frame: start + data + optional parity + stop bits.
    function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/serial_fifo.sv
// Synchronous single-clock FIFO with occupancy count and a registered overflow pulse.
module serial_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             push, pop;
    logic [WIDTH-1:0] mem [DEPTH];

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign level    = count_q;
    assign overflow = overflow_q;
    assign rd_data  = mem[rd_ptr_q];

    // A write into a full FIFO is dropped even when a pop frees a slot on the same edge.
    always_comb begin
        push       = wr_en && !full;
        pop        = rd_en && !empty;
        overflow_d = wr_en && full;
        wr_ptr_d   = wr_ptr_q + AW'(push);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/serial_tx_fifo.sv
// Parametrised UART transmitter fed by a FIFO; frames go back-to-back while words are queued.
// Optional line-break generator enabled by defining SERIAL_TX_BREAK_EN.
module serial_tx_fifo
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          fpga_clock,
    input  logic                          reset,
`ifdef SERIAL_TX_BREAK_EN
    input  logic                          send_break,
`endif
    input  logic                          wr_en,
    input  logic [DATA_BITS-1:0]          wr_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          busy,
    output logic                          done,
    output logic                          tx
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = 4;
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);
    localparam logic             ODD_MODE  = (PARITY == PAR_ODD);

`ifdef SERIAL_TX_BREAK_EN
    localparam int BRK_LOW   = 2 * frame_bits(DATA_BITS, PARITY, STOP_BITS) * CLKS_PER_BIT;
    localparam int BRK_TOTAL = BRK_LOW + CLKS_PER_BIT;
    localparam int BRK_W     = $clog2(BRK_TOTAL);

    logic [BRK_W-1:0] brk_cnt_q, brk_cnt_d;
`endif

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 load;
    logic                 bit_end;
    logic                 last_stop;
    logic [DATA_BITS-1:0] fifo_rd_data;

    serial_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (fpga_clock),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (load),
        .rd_data  (fifo_rd_data),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow)
    );

    assign bit_end   = (cnt_q == LAST_CNT);
    assign last_stop = (idx_q == LAST_STOP);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_STOP) && bit_end && last_stop;
    assign tx        = tx_q;

    // tx_d is the line level for the state being entered, so tx changes on the same edge as the state.
    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? '0 : cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        load    = 1'b0;
`ifdef SERIAL_TX_BREAK_EN
        brk_cnt_d = brk_cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
`ifdef SERIAL_TX_BREAK_EN
                if (send_break) begin
                    state_d   = ST_BREAK;
                    tx_d      = 1'b0;
                    brk_cnt_d = '0;
                end else
`endif
                if (!empty) begin
                    load = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (idx_q != LAST_DATA) begin
                        idx_d   = idx_q + IDX_W'(1);
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end else if (PARITY != PAR_NONE) begin
                        state_d = ST_PARITY;
                        tx_d    = par_q;
                    end else begin
                        state_d = ST_STOP;
                        idx_d   = '0;
                        tx_d    = 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    idx_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (!last_stop) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else if (!empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
`ifdef SERIAL_TX_BREAK_EN
            ST_BREAK: begin
                cnt_d = '0;
                if (brk_cnt_q == BRK_W'(BRK_TOTAL - 1)) begin
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                end else begin
                    brk_cnt_d = brk_cnt_q + BRK_W'(1);
                    tx_d      = (brk_cnt_q >= BRK_W'(BRK_LOW - 1));
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                tx_d    = 1'b1;
            end
        endcase

        // Popping the head starts a frame immediately, both from idle and at the end of a stop bit.
        if (load) begin
            state_d = ST_START;
            cnt_d   = '0;
            shift_d = fifo_rd_data;
            par_d   = (^fifo_rd_data) ^ ODD_MODE;
            tx_d    = 1'b0;
        end
    end

    always_ff @(posedge fpga_clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
        end
    end

`ifdef SERIAL_TX_BREAK_EN
    always_ff @(posedge fpga_clock) begin
        if (reset) begin
            brk_cnt_q <= '0;
        end else begin
            brk_cnt_q <= brk_cnt_d;
        end
    end
`endif

    always_ff @(posedge fpga_clock) begin
        shift_q <= shift_d;
        par_q   <= par_d;
    end

endmodule
